// File: rtl/rptr_ctrl_if.sv
// Read-side bus of the async FIFO pointer controller.
// The master modport belongs to the read client; the slave modport belongs to
// the pointer controller, which owns all pointers and status flags.
interface rptr_ctrl_if #(
  parameter int PTR_WIDTH = 4
);
  logic                 r_en;
  logic [PTR_WIDTH:0]   g_wptr_sync;
  logic [PTR_WIDTH:0]   ae_thresh;
  logic                 uf_clr;
  logic [PTR_WIDTH:0]   b_rptr;
  logic [PTR_WIDTH:0]   g_rptr;
  logic [PTR_WIDTH-1:0] r_addr;
  logic                 empty;
  logic                 almost_empty;
  logic [PTR_WIDTH:0]   rlevel;
  logic                 underflow;

  modport master (
    output r_en, g_wptr_sync, ae_thresh, uf_clr,
    input  b_rptr, g_rptr, r_addr, empty, almost_empty, rlevel, underflow
  );

  modport slave (
    input  r_en, g_wptr_sync, ae_thresh, uf_clr,
    output b_rptr, g_rptr, r_addr, empty, almost_empty, rlevel, underflow
  );
endinterface

// File: rtl/rptr_ctrl.sv
// Read-domain pointer controller for the asynchronous FIFO.
// Keeps binary and Gray read pointers, the RAM read address, an exact-assert
// empty flag, a fill level, an almost-empty flag and a sticky underflow flag.
// The Gray write pointer arrives already synchronised into rclk.
module rptr_ctrl #(
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = $clog2(DEPTH),
  parameter int UF_PROTECT = 1
) (
  input logic        rclk,
  input logic        rrst,
  rptr_ctrl_if.slave bus
);
  localparam int W = PTR_WIDTH + 1;

  logic [W-1:0] b_rptr_q;
  logic [W-1:0] g_rptr_q;
  logic         empty_q;
  logic         almost_empty_q;
  logic [W-1:0] rlevel_q;
  logic         underflow_q;

  logic         rd_fire;
  logic [W-1:0] b_next;
  logic [W-1:0] g_next;
  logic [W-1:0] b_wsync;
  logic [W-1:0] level_next;

  // Next-pointer arithmetic, write-pointer decode and next fill level.
  // With protection disabled a read always advances, even while empty.
  always_comb begin
    rd_fire    = bus.r_en & (~empty_q | (UF_PROTECT == 0));
    b_next     = b_rptr_q + W'(rd_fire);
    g_next     = b_next ^ (b_next >> 1);
    b_wsync    = '0;
    for (int i = 0; i < W; i++) begin
      b_wsync[i] = ^(bus.g_wptr_sync >> i);
    end
    level_next = b_wsync - b_next;
  end

  // Pointer, flag and level registers; flags compare against the next pointer
  // so the final read raises empty at the same edge it is accepted.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      b_rptr_q       <= '0;
      g_rptr_q       <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      rlevel_q       <= '0;
    end else begin
      b_rptr_q       <= b_next;
      g_rptr_q       <= g_next;
      empty_q        <= (g_next == bus.g_wptr_sync);
      almost_empty_q <= (level_next <= bus.ae_thresh);
      rlevel_q       <= level_next;
    end
  end

  // Sticky underflow: any read request seen while empty sets it, and a set
  // wins over a clear arriving in the same cycle.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      underflow_q <= 1'b0;
    end else if (bus.r_en && empty_q) begin
      underflow_q <= 1'b1;
    end else if (bus.uf_clr) begin
      underflow_q <= 1'b0;
    end
  end

  assign bus.b_rptr       = b_rptr_q;
  assign bus.g_rptr       = g_rptr_q;
  assign bus.r_addr       = b_rptr_q[PTR_WIDTH-1:0];
  assign bus.empty        = empty_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.rlevel       = rlevel_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_rptr_ctrl.sv
// Self-checking bench for rptr_ctrl with DEPTH=16.
// Two instances share one stimulus stream: one protected, one unprotected.
// A count-based model (read count, write count, modulo 32) predicts outputs.
module tb_rptr_ctrl;
  localparam int DEPTH = 16;
  localparam int PW    = 4;
  localparam int MOD   = 2 * DEPTH;

  logic rclk;
  logic rrst;
  logic r_en;
  logic uf_clr;
  logic [PW:0] g_wptr;
  logic [PW:0] thresh;

  int n_checks;
  int n_fail;

  int   m_r[2];
  logic m_empty[2];
  logic m_uf[2];
  int   w_cnt;

  rptr_ctrl_if #(.PTR_WIDTH(PW)) bus0 ();
  rptr_ctrl_if #(.PTR_WIDTH(PW)) bus1 ();

  assign bus0.r_en        = r_en;
  assign bus0.g_wptr_sync = g_wptr;
  assign bus0.ae_thresh   = thresh;
  assign bus0.uf_clr      = uf_clr;
  assign bus1.r_en        = r_en;
  assign bus1.g_wptr_sync = g_wptr;
  assign bus1.ae_thresh   = thresh;
  assign bus1.uf_clr      = uf_clr;

  rptr_ctrl #(.DEPTH(DEPTH), .PTR_WIDTH(PW), .UF_PROTECT(1)) dut_prot (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus0.slave)
  );

  rptr_ctrl #(.DEPTH(DEPTH), .PTR_WIDTH(PW), .UF_PROTECT(0)) dut_unprot (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus1.slave)
  );

  // Free-running read clock.
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic check_output(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int level_of(input int k);
    return (w_cnt - m_r[k] + MOD) % MOD;
  endfunction

  // Model: one rising edge for instance k given the applied inputs.
  task automatic model_edge(input int k, input logic protect, input logic en,
                            input logic clr, input logic rst, input int th);
    logic fire;
    if (rst) begin
      m_r[k]     = 0;
      m_empty[k] = 1'b1;
      m_uf[k]    = 1'b0;
    end else begin
      if (en && m_empty[k]) m_uf[k] = 1'b1;
      else if (clr)         m_uf[k] = 1'b0;
      fire       = en && (!m_empty[k] || !protect);
      m_r[k]     = (m_r[k] + (fire ? 1 : 0)) % MOD;
      m_empty[k] = (m_r[k] == w_cnt);
    end
  endtask

  task automatic check_dut(input int k, input int th, input logic rst,
                           input int b, input int g, input int a,
                           input logic e, input logic ae, input int lv, input logic uf);
    int lvl;
    int gexp;
    lvl  = rst ? 0 : level_of(k);
    gexp = m_r[k] ^ (m_r[k] >> 1);
    check_output($sformatf("b_rptr[%0d]", k), b, m_r[k]);
    check_output($sformatf("g_rptr[%0d]", k), g, gexp);
    check_output($sformatf("r_addr[%0d]", k), a, m_r[k] % DEPTH);
    check_output($sformatf("empty[%0d]", k), int'(e), int'(m_empty[k]));
    check_output($sformatf("almost_empty[%0d]", k), int'(ae), (rst || lvl <= th) ? 1 : 0);
    check_output($sformatf("rlevel[%0d]", k), lv, lvl);
    check_output($sformatf("underflow[%0d]", k), int'(uf), int'(m_uf[k]));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at negedge.
  task automatic apply_stimulus(input logic en, input int wc, input int th,
                                input logic clr, input logic rst);
    w_cnt  = wc % MOD;
    r_en   = en;
    g_wptr = PW'(0) + (5'(w_cnt) ^ (5'(w_cnt) >> 1));
    thresh = 5'(th);
    uf_clr = clr;
    rrst   = rst;
    @(posedge rclk);
    model_edge(0, 1'b1, en, clr, rst, th);
    model_edge(1, 1'b0, en, clr, rst, th);
    @(negedge rclk);
    check_dut(0, th, rst, int'(bus0.b_rptr), int'(bus0.g_rptr), int'(bus0.r_addr),
              bus0.empty, bus0.almost_empty, int'(bus0.rlevel), bus0.underflow);
    check_dut(1, th, rst, int'(bus1.b_rptr), int'(bus1.g_rptr), int'(bus1.r_addr),
              bus1.empty, bus1.almost_empty, int'(bus1.rlevel), bus1.underflow);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int w;
    int th;
    logic en;
    logic clr;
    logic rst;
    n_checks = 0;
    n_fail   = 0;
    w_cnt    = 0;
    for (int k = 0; k < 2; k++) begin
      m_r[k] = 0; m_empty[k] = 1'b1; m_uf[k] = 1'b0;
    end
    r_en = 1'b0; uf_clr = 1'b0; rrst = 1'b1; g_wptr = '0; thresh = '0;
    @(negedge rclk);

    // Reset held two cycles with a read request present.
    apply_stimulus(1'b1, 0, 2, 1'b0, 1'b1);
    apply_stimulus(1'b1, 0, 2, 1'b0, 1'b1);

    // Drain five entries to empty, then keep requesting.
    apply_stimulus(1'b0, 5, 2, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 5, 2, 1'b0, 1'b0);

    // Underflow clear, then request and clear together while empty.
    apply_stimulus(1'b0, 5, 2, 1'b1, 1'b0);
    apply_stimulus(1'b1, 5, 2, 1'b1, 1'b0);
    apply_stimulus(1'b0, 5, 2, 1'b0, 1'b0);

    // Wrap: read up to 15, then write pointer at 17 and read twice.
    apply_stimulus(1'b0, 0, 2, 1'b1, 1'b1);
    apply_stimulus(1'b0, 15, 2, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) apply_stimulus(1'b1, 15, 2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 17, 2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 17, 2, 1'b0, 1'b0);

    // Last read coinciding with a new write keeps empty low.
    apply_stimulus(1'b0, 18, 2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 19, 2, 1'b0, 1'b0);

    // Reset mid-stream at level 7 with a read request.
    apply_stimulus(1'b0, 25, 2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 25, 2, 1'b0, 1'b1);

    // Read while empty: unprotected instance advances anyway.
    apply_stimulus(1'b1, 0, 2, 1'b0, 1'b0);
    apply_stimulus(1'b0, 0, 2, 1'b1, 1'b1);

    // Randomized traffic with a legal write side for the protected instance.
    w = 0;
    for (int i = 0; i < 400; i++) begin
      en  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 63) == 0);
      th  = $urandom_range(0, DEPTH);
      if (rst) w = 0;
      else if (level_of(0) < DEPTH && $urandom_range(0, 1) == 1) w = (w + 1) % MOD;
      apply_stimulus(en, w, th, clr, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rptr_ctrl.md
# rptr_ctrl

Parametrised read-side pointer controller for the asynchronous FIFO, the successor to `rptr_handler`. It sits in the `rclk` domain. It advances the binary and Gray read pointers, drives the RAM read address and derives a registered `empty` flag from the 2-FF-synchronised Gray write pointer. Beyond the previous generation it also reports a read-domain fill level, a programmable almost-empty flag and a sticky underflow flag, and it has an optional unprotected read mode.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 4.
- `PTR_WIDTH`, `$clog2(DEPTH)`: address width; pointers are `PTR_WIDTH+1` bits.
- `UF_PROTECT`, 1: when 1, reads are blocked while `empty`; when 0, `r_en` always advances the pointer (overlay use only).

Ports:
- `rclk`, input, 1: read clock. One clock only.
- `rrst`, input, 1: synchronous, active-high reset.
- `r_en`, input, 1: read request.
- `g_wptr_sync`, input, `PTR_WIDTH+1`: Gray write pointer, already synchronised into `rclk`.
- `ae_thresh`, input, `PTR_WIDTH+1`: almost-empty threshold, 0..`DEPTH`.
- `uf_clr`, input, 1: clears the sticky underflow flag.
- `b_rptr`, output, `PTR_WIDTH+1`: binary read pointer, registered.
- `g_rptr`, output, `PTR_WIDTH+1`: Gray read pointer, registered; it goes to the write-side synchroniser.
- `r_addr`, output, `PTR_WIDTH`: RAM read address, equal to `b_rptr[PTR_WIDTH-1:0]`.
- `empty`, output, 1: FIFO empty, registered.
- `almost_empty`, output, 1: fill level ≤ `ae_thresh`, registered.
- `rlevel`, output, `PTR_WIDTH+1`: read-domain fill level, 0..`DEPTH`, registered.
- `underflow`, output, 1: sticky flag, set by any read attempted while `empty`.

## Operation
- `rd_fire = r_en & (~empty | ~UF_PROTECT)`.
- `b_next = b_rptr + rd_fire`, computed modulo 2^(`PTR_WIDTH+1`); it wraps from `2*DEPTH-1` to 0.
- `g_next = b_next ^ (b_next >> 1)`.
- `b_wsync = gray2bin(g_wptr_sync)`, where bit i is the XOR of bits `PTR_WIDTH` down to i.
- Each `rclk` edge, with `rrst`=0:
  - `b_rptr <= b_next`
  - `g_rptr <= g_next`
  - `empty <= (g_next == g_wptr_sync)`
  - `rlevel <= b_wsync - b_next` (modulo, `PTR_WIDTH+1` bits)
  - `almost_empty <= (b_wsync - b_next) <= ae_thresh` (unsigned compare)
- `underflow`:
  - Set when `r_en & empty` is sampled, regardless of `UF_PROTECT`.
  - Otherwise cleared when `uf_clr`=1.
  - Set takes priority over clear in the same cycle.
- Reset values, applied on an `rclk` edge with `rrst`=1: `b_rptr`=0, `g_rptr`=0, `r_addr`=0, `empty`=1, `almost_empty`=1, `rlevel`=0, `underflow`=0.
- Reset overrides every other input.
- The RAM read is combinational at `r_addr`. Data for a fire is valid in the same cycle, and the pointer moves on the next edge.

## Timing
- `r_en` is sampled at a rising edge. The pointer, flags and level update at that edge: one cycle of latency from request to visible pointer change.
- The `empty` assert is exact in the read domain. The last read, which makes `g_next` equal `g_wptr_sync`, raises `empty` at the same edge, so no extra read is accepted.
- The `empty` deassert is pessimistic by the synchroniser delay, which is outside this block. It deasserts on the first edge after `g_wptr_sync` changes.
- Simultaneous last read and new write arriving in the same cycle: `empty` follows the comparison with the new `g_wptr_sync`, so it stays 0.
- `rlevel` never exceeds `DEPTH` for a legal write side. Wrap-around is handled by the extra MSB.
- `ae_thresh` changes take effect at the next edge.
- Reset asserted mid-stream: all outputs take their reset values at that edge. `r_en` during reset is ignored and does not set `underflow`.

## Test plan
All scenarios use `DEPTH`=16.
- **Reset:** hold `rrst`=1 for 2 cycles with `r_en`=1 → `empty`=1, `almost_empty`=1, `b_rptr`=0, `g_rptr`=0, `rlevel`=0, `underflow`=0.
- **Drain to empty:** set `g_wptr_sync`=5'b00111 (gray 5) and `ae_thresh`=2 → `rlevel`=5, `empty`=0.
  - Hold `r_en`=1: `rlevel` steps 4,3,2,1,0.
  - `almost_empty` rises when `rlevel`=2.
  - `empty`=1 and `b_rptr`=5 after 5 fires; the pointer then holds.
- **Wrap:** preload by reading to `b_rptr`=15, then set `g_wptr_sync`=gray 17 (5'b11001) → after 1 fire `b_rptr`=16 and `g_rptr`=5'b11000; after the second fire `r_addr`=1 and `empty`=1.
- **Underflow:** while `empty`, pulse `r_en` for 1 cycle → `underflow`=1 and sticky, pointer unchanged.
  - `uf_clr`=1 → `underflow`=0 next edge.
  - `r_en`+`uf_clr` together while `empty` → `underflow` stays 1.
- **Simultaneous last read and write:** at `rlevel`=1, fire a read while `g_wptr_sync` advances by 1 in the same cycle → `empty` stays 0 and `rlevel`=1.
- **Reset mid-operation and unprotected mode:**
  - Assert `rrst` with `rlevel`=7 and `r_en`=1 → next edge all reset values, `underflow`=0.
  - With `UF_PROTECT`=0, a read while `empty` → `b_rptr` increments and `underflow`=1.
